// File: rtl/rms_norm_drv_if.sv
// Job/scale/result valid-ready streams between the activation buffer, the
// rms_norm_drv sequencer and the result consumer.
interface rms_norm_drv_if #(
   parameter int VEC_W  = 4,
   parameter int DATA_W = 16
);
   logic                      scale_valid;
   logic                      scale_ready;
   logic [VEC_W*DATA_W-1:0]   scale_vec;
   logic                      in_valid;
   logic                      in_ready;
   logic [VEC_W*DATA_W-1:0]   in_vec;
   logic                      out_valid;
   logic                      out_ready;
   logic [VEC_W*DATA_W-1:0]   out_vec;
   logic                      out_err;

   modport master (
      output scale_valid, scale_vec, in_valid, in_vec, out_ready,
      input  scale_ready, in_ready, out_valid, out_vec, out_err
   );

   modport slave (
      input  scale_valid, scale_vec, in_valid, in_vec, out_ready,
      output scale_ready, in_ready, out_valid, out_vec, out_err
   );
endinterface

// File: rtl/rms_norm_drv.sv
// Sequencer for one rms_norm_sf engine: one job in flight, operands held from
// launch to hand-off. RMS_DRV_TIMEOUT_EN adds a WAIT watchdog (TIMEOUT_CYC).
module rms_norm_drv #(
   parameter int VEC_W       = 4,
   parameter int DATA_W      = 16,
   parameter int TIMEOUT_CYC = 1024,
   parameter int CNT_W       = 16
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_enable,
   rms_norm_drv_if.slave           bus,
   output logic                    o_eng_enable,
   output logic                    o_eng_start,
   output logic [VEC_W*DATA_W-1:0] o_eng_input_arr,
   output logic [VEC_W*DATA_W-1:0] o_eng_scaling_arr,
   input  logic [VEC_W*DATA_W-1:0] i_eng_output_arr,
   input  logic                    i_eng_done,
   output logic                    o_busy,
   output logic                    o_err_timeout,
   output logic [CNT_W-1:0]        o_job_count
);
   localparam int W = VEC_W * DATA_W;

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_HOLD} state_t;

   state_t         r_state, w_next;
   logic [W-1:0]   r_op, r_scale, r_res;
   logic [CNT_W-1:0] r_job_count;
   logic           w_rdy, w_tmo_hit;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_rdy       = 1'b0;
      o_eng_start = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_rdy = 1'b1;
            if (bus.in_valid) w_next = S_LAUNCH;
         end
         // eng_done may still be high from the previous run; not looked at here
         S_LAUNCH: begin
            o_eng_start = 1'b1;
            w_next      = S_WAIT;
         end
         S_WAIT: if (i_eng_done || w_tmo_hit) w_next = S_HOLD;
         S_HOLD: if (bus.out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (!i_enable) begin
         w_next      = r_state;
         w_rdy       = 1'b0;
         o_eng_start = 1'b0;
      end
   end

   assign bus.in_ready    = w_rdy & i_rst_n;
   assign bus.scale_ready = w_rdy & i_rst_n;
   assign bus.out_valid   = (r_state == S_HOLD);
   assign bus.out_vec     = r_res;
   assign o_busy          = (r_state != S_IDLE);
   assign o_eng_enable    = i_enable;
   assign o_eng_input_arr = r_op;
   assign o_eng_scaling_arr = r_scale;
   assign o_job_count     = r_job_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_op        <= '0;
         r_scale     <= '0;
         r_res       <= '0;
         r_job_count <= '0;
      end else if (i_enable) begin
         if (r_state == S_IDLE) begin
            if (bus.scale_valid) r_scale <= bus.scale_vec;
            if (bus.in_valid)    r_op    <= bus.in_vec;
         end
         if (r_state == S_WAIT) begin
            if (i_eng_done)     r_res <= i_eng_output_arr;
            else if (w_tmo_hit) r_res <= '0;
         end
         if (r_state == S_HOLD && bus.out_ready) r_job_count <= r_job_count + 1'b1;
      end
   end

`ifdef RMS_DRV_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] r_tmo_cnt;
   logic          r_err, r_err_timeout;

   // Fires on the TIMEOUT_CYC-th WAIT cycle, so HOLD follows at LAUNCH+TIMEOUT_CYC+1
   assign w_tmo_hit = (r_state == S_WAIT) && !i_eng_done &&
                      (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tmo_cnt     <= '0;
         r_err         <= 1'b0;
         r_err_timeout <= 1'b0;
      end else if (i_enable) begin
         if (r_state == S_LAUNCH) r_tmo_cnt <= '0;
         if (r_state == S_WAIT) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
            if (i_eng_done) begin
               r_err <= 1'b0;
            end else if (w_tmo_hit) begin
               r_err         <= 1'b1;
               r_err_timeout <= 1'b1;
            end
         end
      end
   end

   assign bus.out_err    = r_err;
   assign o_err_timeout  = r_err_timeout;
`else
   assign w_tmo_hit      = 1'b0;
   assign bus.out_err    = 1'b0;
   assign o_err_timeout  = 1'b0;
`endif
endmodule
